universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised multi-mode shift register with a start/busy/done handshake. It supports parallel load, clear, logical and arithmetic shifts and rotates by a programmable amount, executing one bit position per clock. It is the general shift/rotate unit for the datapath, serving the shifter path and serial-conversion users that need multi-bit shifts without a barrel shifter.

## Interface
- DATA_WIDTH, 8, register width in bits; legal values are 2 and above.
- AMT_WIDTH, 4, width of the shift-amount field; amounts 0..2**AMT_WIDTH-1 are legal.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset. Single clock domain.
- start  in  1  requests an operation; accepted only on an edge where busy=0.
- mode  in  3  operation select, captured on acceptance: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLEAR.
- amount  in  AMT_WIDTH  number of one-bit steps, captured on acceptance; used only by modes 2–6.
- serialIn  in  1  fill bit for SHL/SHR; sampled live on every shift edge.
- inputData  in  DATA_WIDTH  parallel load value; sampled on the acceptance edge.
- outputData  out  DATA_WIDTH  register contents.
- serialOut  out  1  registered copy of the last bit shifted out.
- busy  out  1  high while a multi-cycle shift is in progress.
- done  out  1  one-cycle pulse on completion.

## Operation
- FSM states:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- Acceptance: start=1 on an edge in IDLE or DONE (busy=0). The block latches mode and amount into internal registers. start seen in SHIFT is ignored and is not queued.
- Acceptance edge, single-cycle ops: HOLD, LOAD (outputData←inputData), CLEAR (outputData←0), and any shift mode with amount=0 (data unchanged). The op completes on the acceptance edge and the FSM goes to DONE.
- Acceptance edge, shift modes with amount=N>0: outputData is unchanged, the down-counter loads N, and the FSM goes to SHIFT.
- SHIFT: every edge performs one step and decrements the counter. On the edge where the counter goes from 1 to 0, the FSM goes to DONE.
- Step definitions:
  - SHL: data←{data[W-2:0], serialIn}; out bit = data[W-1].
  - SHR: data←{serialIn, data[W-1:1]}; out bit = data[0].
  - ROL: data←{data[W-2:0], data[W-1]}; out bit = data[W-1].
  - ROR: data←{data[0], data[W-1:1]}; out bit = data[0].
  - ASR: data←{data[W-1], data[W-1:1]}; out bit = data[0].
- serialOut updates only on step edges; it holds its value otherwise, including through LOAD and CLEAR.
- Amounts ≥ DATA_WIDTH are executed literally. SHL/SHR fully replace the data with serialIn; ROL/ROR by DATA_WIDTH return the original value.
- DONE: if start=1, a new operation is accepted on this edge (back-to-back allowed). Otherwise the FSM returns to IDLE.
- Reset (rst=0) at any time: outputData=0, serialOut=0, busy=0, done=0, counter=0, FSM=IDLE. An in-flight operation is abandoned.

## Timing
- Reset values: every output is 0.
- Single-cycle ops: the result is visible after acceptance edge E0. done is high for the cycle after E0. busy never asserts.
- N-step shift: busy is high from after E0 through edge E(N). The final result is visible after E(N). done is high for the cycle after E(N). Total latency is N+1 edges from acceptance to done.
- done is always exactly one cycle wide. busy and done are never high together.
- Reset takes effect asynchronously. Deassertion is synchronous in effect: the first accepted start is on the first rising edge with rst=1.

## Test plan
- Reset: drive rst=0 mid-cycle with outputData=0xFF → all outputs are 0 immediately. After release, busy=0 and done=0.
- LOAD 0xA5 → outputData=0xA5 after E0, done high one cycle, busy never high. Then SHL amount 3 with serialIn=1 → busy 3 cycles, outputData=0x2F, serialOut=1, done pulse.
- ASR amount 2 on 0x96 → outputData=0xE5, serialOut=1. ROR amount 8 on 0x3C → busy 8 cycles, outputData=0x3C.
- Handshake: start=1 with SHR in cycle 2 of a ROL amount-4 operation → ignored, ROL result unaffected. start=1 during DONE with SHL amount 0 → accepted, data unchanged, done asserts for a second consecutive cycle.
- Reset mid-operation: ROL amount 5 on 0x81, assert rst after the 2nd step → outputData=0, busy=0, FSM IDLE. A subsequent LOAD 0x12 completes normally.
- CLEAR after SHR with serialIn=0 on 0x01 (serialOut=1) → outputData=0, serialOut stays 1.

Source files
------------

// File: rtl/universal_shift_register_if.sv
// Handshake and data bus of the universal shift register.
// The master drives requests and operands; the slave (the shifter) returns
// the register contents, the serial output bit and the busy/done status.
interface universal_shift_register_if #(
    parameter int DATA_WIDTH = 8,
    parameter int AMT_WIDTH  = 4
);
    logic                  start;
    logic [2:0]            mode;
    logic [AMT_WIDTH-1:0]  amount;
    logic                  serialIn;
    logic [DATA_WIDTH-1:0] inputData;
    logic [DATA_WIDTH-1:0] outputData;
    logic                  serialOut;
    logic                  busy;
    logic                  done;

    modport master (
        output start, mode, amount, serialIn, inputData,
        input  outputData, serialOut, busy, done
    );

    modport slave (
        input  start, mode, amount, serialIn, inputData,
        output outputData, serialOut, busy, done
    );
endinterface

// File: rtl/universal_shift_register.sv
// Multi-mode shift/rotate register that executes one bit position per clock.
// Single-cycle ops (HOLD, LOAD, CLEAR, zero-amount shifts) finish on the
// acceptance edge; N-step shifts run in SHIFT for N edges.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; busy=0, done=0
// SHIFT  | stepping one position per edge, counter > 0; busy=1
// DONE   | one-cycle completion pulse; start here is accepted again
module universal_shift_register #(
    parameter int DATA_WIDTH = 8,
    parameter int AMT_WIDTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    universal_shift_register_if.slave   bus
);
    localparam int W = DATA_WIDTH;

    localparam logic [2:0] M_HOLD  = 3'd0;
    localparam logic [2:0] M_LOAD  = 3'd1;
    localparam logic [2:0] M_SHL   = 3'd2;
    localparam logic [2:0] M_SHR   = 3'd3;
    localparam logic [2:0] M_ROL   = 3'd4;
    localparam logic [2:0] M_ROR   = 3'd5;
    localparam logic [2:0] M_ASR   = 3'd6;
    localparam logic [2:0] M_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         data_q, data_d;
    logic                 sout_q, sout_d;
    logic [AMT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state, datapath step and registered status outputs.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        case (state_q)
            ST_SHIFT: begin
                case (mode_q)
                    M_SHL: begin
                        data_d = {data_q[W-2:0], bus.serialIn};
                        sout_d = data_q[W-1];
                    end
                    M_SHR: begin
                        data_d = {bus.serialIn, data_q[W-1:1]};
                        sout_d = data_q[0];
                    end
                    M_ROL: begin
                        data_d = {data_q[W-2:0], data_q[W-1]};
                        sout_d = data_q[W-1];
                    end
                    M_ROR: begin
                        data_d = {data_q[0], data_q[W-1:1]};
                        sout_d = data_q[0];
                    end
                    M_ASR: begin
                        data_d = {data_q[W-1], data_q[W-1:1]};
                        sout_d = data_q[0];
                    end
                    default: begin
                        // Only shift modes ever reach SHIFT.
                        data_d = data_q;
                    end
                endcase
                cnt_d = cnt_q - AMT_WIDTH'(1);
                if (cnt_q == AMT_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE drops to IDLE otherwise.
                state_d = ST_IDLE;
                if (bus.start) begin
                    mode_d  = bus.mode;
                    state_d = ST_DONE;
                    case (bus.mode)
                        M_HOLD:  data_d = data_q;
                        M_LOAD:  data_d = bus.inputData;
                        M_CLEAR: data_d = '0;
                        default: begin
                            if (bus.amount != '0) begin
                                cnt_d   = bus.amount;
                                state_d = ST_SHIFT;
                            end
                        end
                    endcase
                end
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= M_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.outputData = data_q;
    assign bus.serialOut  = sout_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// arithmetic reference model.
module tb_universal_shift_register;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam int FULL = 1 << W;
    localparam int MSB  = 1 << (W - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    universal_shift_register_if #(.DATA_WIDTH(W), .AMT_WIDTH(AW)) bus ();

    universal_shift_register #(.DATA_WIDTH(W), .AMT_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: register value, last out bit, steps still to run,
    // the op being stepped, and whether this cycle is the completion cycle.
    int m_data = 0;
    int m_sout = 0;
    int m_left = 0;
    int m_op   = 0;
    int m_done = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data = 0; m_sout = 0; m_left = 0; m_op = 0; m_done = 0;
        end else if (m_left > 0) begin
            int si;
            si = int'(bus.serialIn);
            case (m_op)
                2: begin m_sout = m_data / MSB; m_data = (m_data * 2 + si) % FULL; end
                3: begin m_sout = m_data % 2;   m_data = m_data / 2 + si * MSB; end
                4: begin m_sout = m_data / MSB; m_data = (m_data * 2) % FULL + m_data / MSB; end
                5: begin m_sout = m_data % 2;   m_data = m_data / 2 + (m_data % 2) * MSB; end
                default: begin
                    m_sout = m_data % 2;
                    m_data = m_data / 2 + ((m_data >= MSB) ? MSB : 0);
                end
            endcase
            m_left = m_left - 1;
            m_done = (m_left == 0) ? 1 : 0;
        end else begin
            m_done = 0;
            if (bus.start) begin
                m_done = 1;
                case (int'(bus.mode))
                    0: ;
                    1: m_data = int'(bus.inputData);
                    7: m_data = 0;
                    default: begin
                        if (bus.amount != '0) begin
                            m_left = int'(bus.amount);
                            m_op   = int'(bus.mode);
                            m_done = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks = checks + 1;
            if (int'(bus.outputData) != m_data) begin
                errors = errors + 1;
                $display("FAIL cmp_data t=%0t dut=%0h model=%0h", $time, bus.outputData, m_data);
            end
            checks = checks + 1;
            if (int'(bus.serialOut) != m_sout) begin
                errors = errors + 1;
                $display("FAIL cmp_sout t=%0t dut=%0d model=%0d", $time, bus.serialOut, m_sout);
            end
            checks = checks + 1;
            if (int'(bus.busy) != ((m_left > 0) ? 1 : 0)) begin
                errors = errors + 1;
                $display("FAIL cmp_busy t=%0t dut=%0d model=%0d", $time, bus.busy, (m_left > 0));
            end
            checks = checks + 1;
            if (int'(bus.done) != m_done) begin
                errors = errors + 1;
                $display("FAIL cmp_done t=%0t dut=%0d model=%0d", $time, bus.done, m_done);
            end
            checks = checks + 1;
            if (bus.busy && bus.done) begin
                errors = errors + 1;
                $display("FAIL busy_and_done t=%0t dut=11 required=not both", $time);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s dut=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge; returns just after that edge.
    task automatic start_op(input int m, input int a, input int d, input int si);
        bus.start     = 1'b1;
        bus.mode      = 3'(m);
        bus.amount    = AW'(a);
        bus.inputData = W'(d);
        bus.serialIn  = si[0];
        align();
        bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; counts busy cycles before it.
    task automatic wait_done(input string name, output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) nbusy = nbusy + 1;
        end
        checks = checks + 1;
        if (!seen) begin
            errors = errors + 1;
            $display("FAIL %s_timeout dut=no_done required=done within 100 cycles", name);
        end
    endtask

    initial begin
        int nb;
        bus.start = 1'b0; bus.mode = '0; bus.amount = '0;
        bus.serialIn = 1'b0; bus.inputData = '0;

        #3 rst = 1'b0;
        chk_en = 1'b1;
        align();
        rst = 1'b1;
        @(negedge clk);
        lit("reset_data", int'(bus.outputData), 0);
        lit("reset_busy", int'(bus.busy), 0);
        lit("reset_done", int'(bus.done), 0);
        align();

        // LOAD then SHL 3 with serialIn=1
        start_op(1, 0, 'hA5, 0);
        wait_done("load_a5", nb);
        lit("load_data", int'(bus.outputData), 'hA5);
        lit("load_busy_cycles", nb, 0);
        align();
        start_op(2, 3, 0, 1);
        wait_done("shl3", nb);
        lit("shl3_data", int'(bus.outputData), 'h2F);
        lit("shl3_sout", int'(bus.serialOut), 1);
        lit("shl3_busy_cycles", nb, 3);
        align();

        // ASR 2 on 0x96
        start_op(1, 0, 'h96, 0);
        wait_done("load_96", nb);
        align();
        start_op(6, 2, 0, 0);
        wait_done("asr2", nb);
        lit("asr2_data", int'(bus.outputData), 'hE5);
        lit("asr2_sout", int'(bus.serialOut), 1);
        align();

        // ROR by full width returns the original value
        start_op(1, 0, 'h3C, 0);
        wait_done("load_3c", nb);
        align();
        start_op(5, 8, 0, 0);
        wait_done("ror8", nb);
        lit("ror8_data", int'(bus.outputData), 'h3C);
        lit("ror8_busy_cycles", nb, 8);
        align();

        // start during SHIFT is ignored; start during DONE is accepted
        start_op(4, 4, 0, 0);
        align();
        bus.start = 1'b1; bus.mode = 3'd3; bus.amount = AW'(1);
        align();
        bus.start = 1'b0;
        wait_done("rol4", nb);
        lit("rol4_data", int'(bus.outputData), 'hC3);
        bus.start = 1'b1; bus.mode = 3'd2; bus.amount = '0;
        align();
        bus.start = 1'b0;
        @(negedge clk);
        lit("b2b_done", int'(bus.done), 1);
        lit("b2b_data", int'(bus.outputData), 'hC3);
        align();

        // CLEAR keeps serialOut
        start_op(1, 0, 'h01, 0);
        wait_done("load_01", nb);
        align();
        start_op(3, 1, 0, 0);
        wait_done("shr1", nb);
        lit("shr1_sout", int'(bus.serialOut), 1);
        align();
        start_op(7, 0, 0, 0);
        wait_done("clear", nb);
        lit("clear_data", int'(bus.outputData), 0);
        lit("clear_sout", int'(bus.serialOut), 1);
        align();

        // Asynchronous reset mid-cycle with data 0xFF
        start_op(1, 0, 'hFF, 0);
        wait_done("load_ff", nb);
        #2 rst = 1'b0;
        #1;
        lit("async_rst_data", int'(bus.outputData), 0);
        lit("async_rst_sout", int'(bus.serialOut), 0);
        lit("async_rst_done", int'(bus.done), 0);
        align();
        rst = 1'b1;
        @(negedge clk);
        lit("post_rst_busy", int'(bus.busy), 0);
        lit("post_rst_done", int'(bus.done), 0);
        align();

        // Reset in the middle of ROL 5 on 0x81, then a normal LOAD
        start_op(1, 0, 'h81, 0);
        wait_done("load_81", nb);
        align();
        start_op(4, 5, 0, 0);
        align();
        align();
        rst = 1'b0;
        #1;
        lit("midop_rst_data", int'(bus.outputData), 0);
        lit("midop_rst_busy", int'(bus.busy), 0);
        align();
        rst = 1'b1;
        start_op(1, 0, 'h12, 0);
        wait_done("load_12", nb);
        lit("reload_data", int'(bus.outputData), 'h12);
        align();

        // Randomized traffic, including ignored and back-to-back starts
        for (int i = 0; i < 4000; i++) begin
            bus.start     = ($urandom_range(0, 2) == 0);
            bus.mode      = 3'($urandom_range(0, 7));
            bus.amount    = AW'($urandom_range(0, (1 << AW) - 1));
            bus.inputData = W'($urandom_range(0, FULL - 1));
            bus.serialIn  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b0;
                #2 rst = 1'b1;
            end
            align();
        end
        bus.start = 1'b0;
        repeat (20) align();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
